// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between overlay stages.
// Modports "in"/"out" are the stage-side views; master/slave are the same views under generic names.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite.sv
// Three-stage overlay: composites a 64x64 sprite from a synchronous ROM over the background.
// Position and mirroring are sampled once per frame on the vblnk rising edge.
module draw_sprite #(
    parameter int          SPR_W  = 64,
    parameter int          SPR_H  = 64,
    parameter logic [11:0] TRANSP = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           in,
    vga_if.out          out,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    input  logic        mirror,
    output logic [11:0] rom_addr,
    input  logic [11:0] rom_data
);

    localparam logic [5:0] COL_MAX = 6'(SPR_W - 1);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    logic [10:0] xpos_q;
    logic [10:0] ypos_q;
    logic        mirror_q;
    logic        vblnk_prev;
    logic        hit1;
    logic        hit2;
    vga_t        s1;
    vga_t        s2;

    logic        hit;
    logic [11:0] addr_next;
    logic [11:0] hc12;
    logic [11:0] vc12;
    logic [11:0] xs12;
    logic [11:0] ys12;
    logic [10:0] dx_full;
    logic [10:0] dy_full;
    logic [5:0]  dx;
    logic [5:0]  dy;
    logic [5:0]  col;
    vga_t        in_fields;

    // One extra bit on the compares keeps xpos_q+SPR_W from wrapping near 2047.
    always_comb begin
        hc12      = {1'b0, in.hcount};
        vc12      = {1'b0, in.vcount};
        xs12      = {1'b0, xpos_q};
        ys12      = {1'b0, ypos_q};
        hit       = !in.hblnk && !in.vblnk
                    && (hc12 >= xs12) && (hc12 < xs12 + 12'(SPR_W))
                    && (vc12 >= ys12) && (vc12 < ys12 + 12'(SPR_H));
        dx_full   = in.hcount - xpos_q;
        dy_full   = in.vcount - ypos_q;
        dx        = dx_full[5:0];
        dy        = dy_full[5:0];
        col       = mirror_q ? (COL_MAX - dx) : dx;
        addr_next = hit ? {dy, col} : 12'h000;
        in_fields = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync,
                      vsync: in.vsync, hblnk: in.hblnk, vblnk: in.vblnk, rgb: in.rgb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xpos_q     <= '0;
            ypos_q     <= '0;
            mirror_q   <= 1'b0;
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= in.vblnk;
            if (in.vblnk && !vblnk_prev) begin
                xpos_q   <= xpos;
                ypos_q   <= ypos;
                mirror_q <= mirror;
            end
        end
    end

    // S2 lines up with the ROM's registered output, so compositing happens on the way into S3.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            hit1       <= 1'b0;
            hit2       <= 1'b0;
            s1         <= '0;
            s2         <= '0;
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            rom_addr   <= addr_next;
            hit1       <= hit;
            s1         <= in_fields;
            hit2       <= hit1;
            s2         <= s1;
            out.hcount <= s2.hcount;
            out.vcount <= s2.vcount;
            out.hsync  <= s2.hsync;
            out.vsync  <= s2.vsync;
            out.hblnk  <= s2.hblnk;
            out.vblnk  <= s2.vblnk;
            out.rgb    <= (hit2 && rom_data != TRANSP) ? rom_data : s2.rgb;
        end
    end

endmodule
